tree_mac_result_collector: RTL and testbench
============================================

TREE_MAC_RESULT_COLLECTOR -- requirements
Module: tree_mac_result_collector

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of partial sums and results.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH_I, default 8, giving the width of the output-row address.
REQ-003 The block SHALL have parameter ADDRESS_WIDTH_K, default 8, giving the width of the k-tile index.
REQ-004 The block SHALL have parameter NUM_ROWS, default 16, giving the number of accumulator entries; it is a power of 2 and at most 2^ADDRESS_WIDTH_I.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO depth; it is a power of 2 and at least 2.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port sum_in, input, DATA_WIDTH bits: the dot-product partial sum from the MAC tree.
REQ-009 The block SHALL have port addr_i_in, input, ADDRESS_WIDTH_I bits: the output-row address of sum_in.
REQ-010 The block SHALL have port addr_k_in, input, ADDRESS_WIDTH_K bits: the k-tile index of sum_in.
REQ-011 The block SHALL have port val_in, input, 1 bit: sum_in, addr_i_in and addr_k_in are valid; there is no backpressure on this input.
REQ-012 The block SHALL have port k_last, input, ADDRESS_WIDTH_K bits: the final k-tile index; it is held static while val_in traffic is in flight.
REQ-013 The block SHALL have port out_val, output, 1 bit: a result is available.
REQ-014 The block SHALL have port out_rdy, input, 1 bit: the consumer accepts the result.
REQ-015 The block SHALL have port out_data, output, DATA_WIDTH bits: the completed result.
REQ-016 The block SHALL have port out_addr, output, ADDRESS_WIDTH_I bits: the full addr_i of the result.
REQ-017 The block SHALL have port fifo_full, output, 1 bit: asserted when FIFO occupancy equals FIFO_DEPTH.
REQ-018 The block SHALL have port overflow, output, 1 bit: sticky flag set when a result is dropped.
REQ-019 The block SHALL have port result_count, output, 16 bits: the number of results pushed into the FIFO, wrapping modulo 2^16.

Function
REQ-020 The accumulator index idx SHALL be addr_i_in[log2(NUM_ROWS)-1:0]; the upper address bits SHALL NOT affect indexing but SHALL be carried to out_addr.
REQ-021 On a val_in beat, the block SHALL form new = sum_in when addr_k_in==0, and new = acc[idx] + sum_in truncated modulo 2^DATA_WIDTH otherwise.
REQ-022 On a val_in beat with addr_k_in != k_last, the block SHALL write acc[idx] <= new and SHALL NOT push to the FIFO.
REQ-023 On a val_in beat with addr_k_in == k_last, the block SHALL push {addr_i_in, new} into the FIFO, write acc[idx] <= 0, and increment result_count.
REQ-024 When addr_k_in > k_last, the beat SHALL be treated as an accumulate per REQ-022, with no push and no error flag.
REQ-025 When k_last==0, every beat SHALL push sum_in directly.
REQ-026 Back-to-back beats to the same idx SHALL accumulate correctly with no bubble, because acc is read combinationally and written at the clock edge.
REQ-027 Input-to-output latency SHALL be 1 cycle: a push at edge t makes out_val=1 in the cycle after edge t, if the FIFO was empty.
REQ-028 The FIFO SHALL be first-word fall-through, with out_val = (occupancy != 0) and out_data/out_addr taken from the head entry.
REQ-029 out_data and out_addr SHALL be 0 while the FIFO is empty.
REQ-030 A pop SHALL occur on any edge where out_val && out_rdy; out_val SHALL NOT depend combinationally on out_rdy.
REQ-031 A simultaneous push and pop SHALL leave occupancy unchanged and SHALL be allowed when the FIFO is full.
REQ-032 A push while full without a pop SHALL be dropped, SHALL set overflow=1, SHALL NOT increment result_count, and SHALL still write acc[idx] <= 0.
REQ-033 The FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH, and results SHALL emerge in push order.
REQ-034 overflow SHALL clear only on reset.

Reset
REQ-035 While reset=1 at a clock edge, the block SHALL clear all acc entries to 0, set FIFO occupancy and pointers to 0, and set out_val=0, out_data=0, out_addr=0, fifo_full=0, overflow=0 and result_count=0.
REQ-036 val_in SHALL be ignored during reset, and a reset mid-operation SHALL discard all partial sums and queued results.

Verification
REQ-037 Scenario: k_last=2, out_rdy=1, idx 3 beats (k=0,sum=10),(k=1,sum=20),(k=2,sum=30) -> one result out_addr=3, out_data=60, one cycle after the third beat; result_count=1.
REQ-038 Scenario: k_last=1, beats (addr 5,k0,200),(addr 5,k1,100) -> out_data=44 (300 mod 256).
REQ-039 Scenario: k_last=0, out_rdy=0, 5 beats on consecutive addresses -> 4 results queued, fifo_full=1, overflow=1, result_count=4; then out_rdy=1 -> addresses 0..3 drain in order.
REQ-040 Scenario: FIFO full with out_rdy=1 and a push in the same cycle -> no drop, overflow stays 0, occupancy stays 4.
REQ-041 Scenario: interleaved rows 1 and 2 with k_last=1 (r1k0=7, r2k0=9, r1k1=1, r2k1=2) -> results (1,8) then (2,11).
REQ-042 Scenario: reset asserted after the k0 beat of row 4, then k1 beat with sum=5 and k_last=1 -> out_data=5 (acc cleared), all status outputs cleared.

Source files
------------

// File: rtl/tree_mac_result_collector.sv
// tree_mac_result_collector
// Collects partial sums coming out of a MAC reduction tree, accumulates them
// per output row across k-tiles, and queues each finished row result in a
// small first-word-fall-through FIFO for a downstream consumer.

module tree_mac_result_collector #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDRESS_WIDTH_I = 8,
    parameter int ADDRESS_WIDTH_K = 8,
    parameter int NUM_ROWS        = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      sum_in,
    input  logic [ADDRESS_WIDTH_I-1:0] addr_i_in,
    input  logic [ADDRESS_WIDTH_K-1:0] addr_k_in,
    input  logic                       val_in,
    input  logic [ADDRESS_WIDTH_K-1:0] k_last,
    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [ADDRESS_WIDTH_I-1:0] out_addr,
    output logic                       fifo_full,
    output logic                       overflow,
    output logic [15:0]                result_count
);

    localparam int IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   OCC_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Per-row running sums
    logic [DATA_WIDTH-1:0] acc [NUM_ROWS];

    // Result queue storage and bookkeeping
    logic [DATA_WIDTH-1:0]      fifo_data [FIFO_DEPTH];
    logic [ADDRESS_WIDTH_I-1:0] fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W:0]             occupancy;

    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] acc_new;
    logic                  is_last;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;

    assign idx = addr_i_in[IDX_W-1:0];

    // New running sum: k-tile 0 starts a fresh row, later tiles add to the stored value
    always_comb begin
        acc_new = sum_in;
        if (addr_k_in != '0) begin
            acc_new = acc[idx] + sum_in;
        end
    end

    // A final-tile beat completes a row; it may enter the queue if there is
    // room, or if the head leaves on the same edge and frees a slot
    always_comb begin
        is_last = val_in && (addr_k_in == k_last);
        pop     = out_val && out_rdy;
        push_ok = is_last && ((occupancy != DEPTH_C) || pop);
        drop    = is_last && !push_ok;
    end

    // Accumulator update; a completed row is always cleared, even if its result is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                acc[i] <= '0;
            end
        end else if (val_in) begin
            acc[idx] <= is_last ? '0 : acc_new;
        end
    end

    // Queue pointers, occupancy and entry writes
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_ok) begin
                fifo_data[wr_ptr] <= acc_new;
                fifo_addr[wr_ptr] <= addr_i_in;
                wr_ptr            <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop) begin
                occupancy <= occupancy + OCC_ONE;
            end else if (pop && !push_ok) begin
                occupancy <= occupancy - OCC_ONE;
            end
        end
    end

    // Sticky drop flag and count of results that made it into the queue
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow     <= 1'b0;
            result_count <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (push_ok) begin
                result_count <= result_count + 16'd1;
            end
        end
    end

    // Head entry is presented directly; outputs read as zero when the queue is empty
    always_comb begin
        out_val   = (occupancy != '0);
        fifo_full = (occupancy == DEPTH_C);
        out_data  = '0;
        out_addr  = '0;
        if (out_val) begin
            out_data = fifo_data[rd_ptr];
            out_addr = fifo_addr[rd_ptr];
        end
    end

endmodule

// File: tb/tb_tree_mac_result_collector.sv
// Testbench for tree_mac_result_collector: directed scenarios with literal
// expectations plus a queue-based reference model compared every cycle.

module tb_tree_mac_result_collector;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int KW    = 8;
    localparam int ROWS  = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic [DW-1:0] sum_in;
    logic [AW-1:0] addr_i_in;
    logic [KW-1:0] addr_k_in;
    logic          val_in;
    logic [KW-1:0] k_last;
    logic          out_val;
    logic          out_rdy;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          fifo_full;
    logic          overflow;
    logic [15:0]   result_count;

    int checks = 0;
    int errors = 0;

    tree_mac_result_collector #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH_I(AW), .ADDRESS_WIDTH_K(KW),
        .NUM_ROWS(ROWS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .sum_in(sum_in), .addr_i_in(addr_i_in),
        .addr_k_in(addr_k_in), .val_in(val_in), .k_last(k_last),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
        .out_addr(out_addr), .fifo_full(fifo_full), .overflow(overflow),
        .result_count(result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of finished results and an array of row sums
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } entry_t;

    entry_t        m_q[$];
    logic [DW-1:0] m_acc [ROWS];
    logic          m_over;
    logic [15:0]   m_cnt;
    bit            m_valid = 0;
    int            m_idx;
    logic [DW-1:0] m_new;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++) m_acc[i] = '0;
            m_q.delete();
            m_over  = 1'b0;
            m_cnt   = '0;
            m_valid = 1;
        end else if (m_valid) begin
            if (m_q.size() != 0 && out_rdy) void'(m_q.pop_front());
            if (val_in) begin
                m_idx = int'(addr_i_in) % ROWS;
                m_new = (addr_k_in == 0) ? sum_in : DW'(m_acc[m_idx] + sum_in);
                if (addr_k_in == k_last) begin
                    m_acc[m_idx] = '0;
                    if (m_q.size() < DEPTH) begin
                        m_q.push_back('{a: addr_i_in, d: m_new});
                        m_cnt = m_cnt + 16'd1;
                    end else begin
                        m_over = 1'b1;
                    end
                end else begin
                    m_acc[m_idx] = m_new;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model out_val", 32'(out_val), 32'(m_q.size() != 0));
            checkOutput("model out_data", 32'(out_data), (m_q.size() != 0) ? 32'(m_q[0].d) : 32'd0);
            checkOutput("model out_addr", 32'(out_addr), (m_q.size() != 0) ? 32'(m_q[0].a) : 32'd0);
            checkOutput("model fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
            checkOutput("model overflow", 32'(overflow), 32'(m_over));
            checkOutput("model result_count", 32'(result_count), 32'(m_cnt));
        end
    end

    // One input beat; returns just after the edge that consumed it
    task automatic applyStimulus(input logic [AW-1:0] a, input logic [KW-1:0] k, input logic [DW-1:0] s);
        val_in    = 1'b1;
        addr_i_in = a;
        addr_k_in = k;
        sum_in    = s;
        @(posedge clk);
        #2;
        val_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; val_in = 1'b0; sum_in = '0; addr_i_in = '0; addr_k_in = '0;
        k_last = '0; out_rdy = 1'b1;
        idle(2);
        checkOutput("reset out_val", 32'(out_val), 0);
        checkOutput("reset out_data", 32'(out_data), 0);
        checkOutput("reset result_count", 32'(result_count), 0);
        reset = 1'b0;

        // Three-tile accumulation on row 3
        k_last = 8'd2;
        applyStimulus(8'd3, 8'd0, 8'd10);
        applyStimulus(8'd3, 8'd1, 8'd20);
        checkOutput("s1 no early result", 32'(out_val), 0);
        applyStimulus(8'd3, 8'd2, 8'd30);
        checkOutput("s1 out_val", 32'(out_val), 1);
        checkOutput("s1 out_data", 32'(out_data), 60);
        checkOutput("s1 out_addr", 32'(out_addr), 3);
        checkOutput("s1 result_count", 32'(result_count), 1);
        idle(1);
        checkOutput("s1 drained", 32'(out_val), 0);

        // Wrap-around of the sum
        k_last = 8'd1;
        applyStimulus(8'd5, 8'd0, 8'd200);
        applyStimulus(8'd5, 8'd1, 8'd100);
        checkOutput("s2 out_data", 32'(out_data), 44);
        checkOutput("s2 out_addr", 32'(out_addr), 5);
        idle(1);

        // Overflow: five direct pushes with the consumer stalled
        k_last = 8'd0; out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(8'(i), 8'd0, 8'(10 + i));
        checkOutput("s3 fifo_full", 32'(fifo_full), 1);
        checkOutput("s3 overflow", 32'(overflow), 1);
        checkOutput("s3 result_count", 32'(result_count), 6);
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("s3 drain addr", 32'(out_addr), 32'(i));
            checkOutput("s3 drain data", 32'(out_data), 32'(10 + i));
            idle(1);
        end
        checkOutput("s3 empty", 32'(out_val), 0);
        checkOutput("s3 overflow sticky", 32'(overflow), 1);

        // Push into a full queue while the head pops
        doReset();
        checkOutput("s4 overflow cleared", 32'(overflow), 0);
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(8'(i), 8'd0, 8'(20 + i));
        checkOutput("s4 full", 32'(fifo_full), 1);
        out_rdy = 1'b1;
        applyStimulus(8'd7, 8'd0, 8'd77);
        checkOutput("s4 no overflow", 32'(overflow), 0);
        checkOutput("s4 still full", 32'(fifo_full), 1);
        checkOutput("s4 result_count", 32'(result_count), 5);
        checkOutput("s4 head addr", 32'(out_addr), 1);
        idle(3);
        checkOutput("s4 last addr", 32'(out_addr), 7);
        checkOutput("s4 last data", 32'(out_data), 77);
        idle(1);

        // Interleaved rows
        k_last = 8'd1;
        applyStimulus(8'd1, 8'd0, 8'd7);
        applyStimulus(8'd2, 8'd0, 8'd9);
        applyStimulus(8'd1, 8'd1, 8'd1);
        checkOutput("s5 row1 addr", 32'(out_addr), 1);
        checkOutput("s5 row1 data", 32'(out_data), 8);
        applyStimulus(8'd2, 8'd1, 8'd2);
        checkOutput("s5 row2 addr", 32'(out_addr), 2);
        checkOutput("s5 row2 data", 32'(out_data), 11);
        idle(1);

        // Upper address bits share an accumulator but travel with the result
        applyStimulus(8'h21, 8'd0, 8'd3);
        applyStimulus(8'h31, 8'd1, 8'd4);
        checkOutput("s6 out_addr", 32'(out_addr), 32'h31);
        checkOutput("s6 out_data", 32'(out_data), 7);
        idle(1);

        // Tile index beyond k_last accumulates without pushing
        applyStimulus(8'd6, 8'd0, 8'd5);
        applyStimulus(8'd6, 8'd3, 8'd6);
        checkOutput("s7 no push", 32'(out_val), 0);
        applyStimulus(8'd6, 8'd1, 8'd1);
        checkOutput("s7 out_data", 32'(out_data), 12);
        idle(1);

        // Reset mid-row discards the partial sum and ignores beats during reset
        applyStimulus(8'd4, 8'd0, 8'd50);
        reset = 1'b1;
        applyStimulus(8'd4, 8'd1, 8'd99);
        reset = 1'b0;
        checkOutput("s8 out_val", 32'(out_val), 0);
        checkOutput("s8 result_count", 32'(result_count), 0);
        checkOutput("s8 overflow", 32'(overflow), 0);
        checkOutput("s8 fifo_full", 32'(fifo_full), 0);
        applyStimulus(8'd4, 8'd1, 8'd5);
        checkOutput("s8 out_data", 32'(out_data), 5);
        checkOutput("s8 out_addr", 32'(out_addr), 4);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
